// File: rtl/index_decode_scoreboard.sv
// rtl/index_decode_scoreboard.sv - binary-index busy bitmap with one-hot decode, count and error pulses
// Sets/clears entries by binary index; all outputs are registered one cycle after the request.
module index_decode_scoreboard #(
  parameter int BITS = 32,
  localparam int IDXW = $clog2(BITS),
  localparam int CNTW = $clog2(BITS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            set_valid,
  input  logic [IDXW-1:0] set_idx,
  input  logic            clr_valid,
  input  logic [IDXW-1:0] clr_idx,
  output logic [BITS-1:0] busy,
  output logic [CNTW-1:0] busy_count,
  output logic            full,
  output logic            empty,
  output logic [BITS-1:0] set_onehot,
  output logic            set_err,
  output logic            clr_err
);

  logic [BITS-1:0] r_busy;
  logic [CNTW-1:0] r_count;
  logic            r_full;
  logic            r_empty;
  logic [BITS-1:0] r_set_oh;
  logic            r_set_err;
  logic            r_clr_err;

  logic [BITS-1:0] w_set_oh;
  logic [BITS-1:0] w_clr_oh;
  logic            w_clr_eff;
  logic [BITS-1:0] w_busy_after_clr;
  logic            w_set_eff;
  logic [BITS-1:0] w_busy_next;
  logic [CNTW-1:0] w_count_next;

  // Indices >= BITS match no position and so decode to all-zero.
  always_comb begin
    w_set_oh = '0;
    w_clr_oh = '0;
    for (int i = 0; i < BITS; i++) begin
      w_set_oh[i] = (set_idx == IDXW'(i));
      w_clr_oh[i] = (clr_idx == IDXW'(i));
    end
  end

  assign w_clr_eff        = clr_valid & (|(w_clr_oh & r_busy));
  assign w_busy_after_clr = w_clr_eff ? (r_busy & ~w_clr_oh) : r_busy;

  // The set sees the bitmap after the same-cycle clear, so clear+set of one busy entry succeeds.
  assign w_set_eff    = set_valid & (|w_set_oh) & ~(|(w_set_oh & w_busy_after_clr));
  assign w_busy_next  = w_set_eff ? (w_busy_after_clr | w_set_oh) : w_busy_after_clr;
  assign w_count_next = r_count + CNTW'(w_set_eff) - CNTW'(w_clr_eff);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_busy    <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_set_oh  <= '0;
      r_set_err <= 1'b0;
      r_clr_err <= 1'b0;
    end else begin
      r_busy    <= w_busy_next;
      r_count   <= w_count_next;
      r_full    <= (w_count_next == CNTW'(BITS));
      r_empty   <= (w_count_next == '0);
      r_set_oh  <= w_set_eff ? w_set_oh : '0;
      r_set_err <= set_valid & ~w_set_eff;
      r_clr_err <= clr_valid & ~w_clr_eff;
    end
  end

  assign busy       = r_busy;
  assign busy_count = r_count;
  assign full       = r_full;
  assign empty      = r_empty;
  assign set_onehot = r_set_oh;
  assign set_err    = r_set_err;
  assign clr_err    = r_clr_err;

endmodule

// File: tb/tb_index_decode_scoreboard.sv
// tb/tb_index_decode_scoreboard.sv - table, hand-sequence and random scoreboard bench
// Drives a BITS=8 and a BITS=6 instance; expected records are queued at drive time, popped after the edge.
module tb_index_decode_scoreboard;

  typedef struct {
    logic       rst, flush, sv;
    logic [2:0] si;
    logic       cv;
    logic [2:0] ci;
    logic [7:0] busy;
    logic [3:0] cnt;
    logic       full, empty;
    logic [7:0] oh;
    logic       serr, cerr;
  } vec_t;

  typedef struct {
    int   dut;
    vec_t v;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, flush8, sv8, cv8;
  logic [2:0] si8, ci8;
  logic [7:0] busy8, oh8;
  logic [3:0] cnt8;
  logic       full8, empty8, serr8, cerr8;

  logic       rst6, flush6, sv6, cv6;
  logic [2:0] si6, ci6;
  logic [5:0] busy6, oh6;
  logic [2:0] cnt6;
  logic       full6, empty6, serr6, cerr6;

  index_decode_scoreboard #(.BITS(8)) u_dut8 (
    .clk(clk), .rst(rst8), .flush(flush8),
    .set_valid(sv8), .set_idx(si8), .clr_valid(cv8), .clr_idx(ci8),
    .busy(busy8), .busy_count(cnt8), .full(full8), .empty(empty8),
    .set_onehot(oh8), .set_err(serr8), .clr_err(cerr8)
  );

  index_decode_scoreboard #(.BITS(6)) u_dut6 (
    .clk(clk), .rst(rst6), .flush(flush6),
    .set_valid(sv6), .set_idx(si6), .clr_valid(cv6), .clr_idx(ci6),
    .busy(busy6), .busy_count(cnt6), .full(full6), .empty(empty6),
    .set_onehot(oh6), .set_err(serr6), .clr_err(cerr6)
  );

  int         n_vec = 0;
  int         n_bad = 0;
  sb_t        sb_q[$];
  vec_t       tbl8[$];
  vec_t       tbl6[$];
  logic [7:0] m8 = '0;
  logic [7:0] m6 = '0;

  function automatic vec_t mk(input int bits, input logic rst, input logic flush,
                              input logic sv, input logic [2:0] si, input logic cv,
                              input logic [2:0] ci, input logic [7:0] busy,
                              input logic [3:0] cnt, input logic [7:0] oh,
                              input logic serr, input logic cerr);
    vec_t r;
    r.rst = rst; r.flush = flush; r.sv = sv; r.si = si; r.cv = cv; r.ci = ci;
    r.busy = busy; r.cnt = cnt; r.oh = oh; r.serr = serr; r.cerr = cerr;
    r.full  = (int'(cnt) == bits);
    r.empty = (cnt == 4'd0);
    return r;
  endfunction

  // Reference: clear judged on the old bitmap, set judged on the bitmap after that clear.
  function automatic vec_t model(input int bits, input logic [7:0] cur, input vec_t in);
    vec_t       r;
    logic [7:0] nb;
    r = in;
    r.busy = '0; r.oh = '0; r.serr = 1'b0; r.cerr = 1'b0;
    if (!(in.rst || in.flush)) begin
      nb = cur;
      if (in.cv) begin
        if (int'(in.ci) < bits && cur[in.ci]) nb[in.ci] = 1'b0;
        else r.cerr = 1'b1;
      end
      if (in.sv) begin
        if (int'(in.si) < bits && !nb[in.si]) begin
          nb[in.si]   = 1'b1;
          r.oh[in.si] = 1'b1;
        end else begin
          r.serr = 1'b1;
        end
      end
      r.busy = nb;
    end
    r.cnt   = 4'($countones(r.busy));
    r.full  = (int'(r.cnt) == bits);
    r.empty = (r.cnt == 4'd0);
    return r;
  endfunction

  task automatic chk(input string name, input int dut, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (BITS=%0d) at %0t: got %0h expected %0h", name, dut == 0 ? 8 : 6, $time, act, exp);
    end
  endtask

  task automatic apply(input int dut, input vec_t v);
    sb_t e;
    @(negedge clk);
    rst8 = 1'b0; flush8 = 1'b0; sv8 = 1'b0; si8 = '0; cv8 = 1'b0; ci8 = '0;
    rst6 = 1'b0; flush6 = 1'b0; sv6 = 1'b0; si6 = '0; cv6 = 1'b0; ci6 = '0;
    if (dut == 0) begin
      rst8 = v.rst; flush8 = v.flush; sv8 = v.sv; si8 = v.si; cv8 = v.cv; ci8 = v.ci;
    end else begin
      rst6 = v.rst; flush6 = v.flush; sv6 = v.sv; si6 = v.si; cv6 = v.cv; ci6 = v.ci;
    end
    e.dut = dut;
    e.v   = v;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    if (e.dut == 0) begin
      chk("busy", 0, busy8, e.v.busy);
      chk("busy_count", 0, {4'd0, cnt8}, {4'd0, e.v.cnt});
      chk("full", 0, {7'd0, full8}, {7'd0, e.v.full});
      chk("empty", 0, {7'd0, empty8}, {7'd0, e.v.empty});
      chk("set_onehot", 0, oh8, e.v.oh);
      chk("set_err", 0, {7'd0, serr8}, {7'd0, e.v.serr});
      chk("clr_err", 0, {7'd0, cerr8}, {7'd0, e.v.cerr});
      m8 = e.v.busy;
    end else begin
      chk("busy", 1, {2'd0, busy6}, e.v.busy);
      chk("busy_count", 1, {5'd0, cnt6}, {4'd0, e.v.cnt});
      chk("full", 1, {7'd0, full6}, {7'd0, e.v.full});
      chk("empty", 1, {7'd0, empty6}, {7'd0, e.v.empty});
      chk("set_onehot", 1, {2'd0, oh6}, e.v.oh);
      chk("set_err", 1, {7'd0, serr6}, {7'd0, e.v.serr});
      chk("clr_err", 1, {7'd0, cerr6}, {7'd0, e.v.cerr});
      m6 = e.v.busy;
    end
  endtask

  initial begin
    vec_t in;
    vec_t ex;
    rst8 = 1'b1; flush8 = 1'b0; sv8 = 1'b0; si8 = '0; cv8 = 1'b0; ci8 = '0;
    rst6 = 1'b1; flush6 = 1'b0; sv6 = 1'b0; si6 = '0; cv6 = 1'b0; ci6 = '0;

    // BITS=8 directed table: bits, rst, flush, sv, si, cv, ci, busy, cnt, onehot, set_err, clr_err
    tbl8.push_back(mk(8, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0));
    tbl8.push_back(mk(8, 0, 0, 1, 3, 0, 0, 8'h08, 1, 8'h08, 0, 0));
    tbl8.push_back(mk(8, 0, 0, 0, 0, 1, 3, 8'h00, 0, 8'h00, 0, 0));
    for (int k = 0; k < 8; k++)
      tbl8.push_back(mk(8, 0, 0, 1, 3'(k), 0, 0, 8'((1 << (k + 1)) - 1), 4'(k + 1), 8'(1 << k), 0, 0));
    tbl8.push_back(mk(8, 0, 0, 1, 2, 0, 0, 8'hFF, 8, 8'h00, 1, 0));
    tbl8.push_back(mk(8, 0, 0, 1, 0, 1, 0, 8'hFF, 8, 8'h01, 0, 0));
    tbl8.push_back(mk(8, 0, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0));
    tbl8.push_back(mk(8, 0, 0, 1, 3, 0, 0, 8'h08, 1, 8'h08, 0, 0));
    tbl8.push_back(mk(8, 0, 0, 1, 3, 1, 3, 8'h08, 1, 8'h08, 0, 0));
    tbl8.push_back(mk(8, 0, 0, 0, 0, 1, 3, 8'h00, 0, 8'h00, 0, 0));
    tbl8.push_back(mk(8, 0, 0, 1, 3, 1, 3, 8'h08, 1, 8'h08, 0, 1));
    tbl8.push_back(mk(8, 0, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0));
    tbl8.push_back(mk(8, 0, 0, 1, 0, 0, 0, 8'h01, 1, 8'h01, 0, 0));
    tbl8.push_back(mk(8, 0, 0, 1, 2, 0, 0, 8'h05, 2, 8'h04, 0, 0));
    tbl8.push_back(mk(8, 0, 0, 1, 5, 0, 0, 8'h25, 3, 8'h20, 0, 0));
    tbl8.push_back(mk(8, 0, 0, 1, 7, 0, 0, 8'hA5, 4, 8'h80, 0, 0));
    tbl8.push_back(mk(8, 0, 1, 1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0));
    tbl8.push_back(mk(8, 0, 0, 0, 0, 1, 4, 8'h00, 0, 8'h00, 0, 1));
    tbl8.push_back(mk(8, 0, 0, 1, 1, 0, 0, 8'h02, 1, 8'h02, 0, 0));
    tbl8.push_back(mk(8, 0, 0, 1, 6, 1, 1, 8'h40, 1, 8'h40, 0, 0));
    tbl8.push_back(mk(8, 0, 0, 1, 6, 1, 6, 8'h40, 1, 8'h40, 0, 0));
    tbl8.push_back(mk(8, 0, 0, 1, 5, 1, 2, 8'h60, 2, 8'h20, 0, 1));
    tbl8.push_back(mk(8, 1, 0, 1, 0, 1, 5, 8'h00, 0, 8'h00, 0, 0));

    // BITS=6: indices 6 and 7 are out of range
    tbl6.push_back(mk(6, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0));
    tbl6.push_back(mk(6, 0, 0, 1, 7, 0, 0, 8'h00, 0, 8'h00, 1, 0));
    tbl6.push_back(mk(6, 0, 0, 0, 0, 1, 5, 8'h00, 0, 8'h00, 0, 1));
    tbl6.push_back(mk(6, 0, 0, 1, 5, 0, 0, 8'h20, 1, 8'h20, 0, 0));
    tbl6.push_back(mk(6, 0, 0, 1, 6, 1, 5, 8'h00, 0, 8'h00, 1, 0));
    tbl6.push_back(mk(6, 0, 0, 0, 0, 1, 7, 8'h00, 0, 8'h00, 0, 1));
    for (int k = 0; k < 6; k++)
      tbl6.push_back(mk(6, 0, 0, 1, 3'(k), 0, 0, 8'((1 << (k + 1)) - 1), 4'(k + 1), 8'(1 << k), 0, 0));
    tbl6.push_back(mk(6, 0, 0, 1, 4, 0, 0, 8'h3F, 6, 8'h00, 1, 0));

    foreach (tbl8[i]) apply(0, tbl8[i]);
    foreach (tbl6[i]) apply(1, tbl6[i]);

    // Multi-cycle random run with occasional mid-stream reset and flush
    for (int n = 0; n < 10000; n++) begin
      int dut;
      dut      = (n < 8000) ? 0 : 1;
      in       = mk(8, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
      in.rst   = ($urandom_range(0, 299) == 0);
      in.flush = ($urandom_range(0, 59) == 0);
      in.sv    = ($urandom_range(0, 99) < 65);
      in.si    = 3'($urandom_range(0, 7));
      in.cv    = ($urandom_range(0, 99) < 50);
      in.ci    = 3'($urandom_range(0, 7));
      ex = model(dut == 0 ? 8 : 6, dut == 0 ? m8 : m6, in);
      apply(dut, ex);
    end

    @(negedge clk);
    rst8 = 1'b0; flush8 = 1'b0; sv8 = 1'b0; cv8 = 1'b0;
    rst6 = 1'b0; flush6 = 1'b0; sv6 = 1'b0; cv6 = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/index_decode_scoreboard.md
Name: index_decode_scoreboard

Overview:
- Converts binary entry indices into one-hot form and keeps them in a BITS-wide busy bitmap. This is the inverse of the one-hot-to-binary encode path.
- The allocate side sets busy bits by binary index. The writeback/free side clears them by binary index. Flush clears everything.
- Downstream it provides the busy vector, a population count, full/empty flags, error pulses, and a registered one-hot of the last accepted set. Used for rename-tag, ROB-slot and LSQ-slot tracking.

Parameters:
- BITS, 32, number of tracked entries (any value >= 2; power of two not required).
- Local parameters (not overridable): IDXW = $clog2(BITS); CNTW = $clog2(BITS+1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  clear all busy state.
- set_valid  in  1  set request this cycle.
- set_idx  in  IDXW  binary index to mark busy.
- clr_valid  in  1  clear request this cycle.
- clr_idx  in  IDXW  binary index to mark free.
- busy  out  BITS  registered busy bitmap; bit i = entry i busy.
- busy_count  out  CNTW  registered number of set bits in busy.
- full  out  1  busy_count == BITS (registered).
- empty  out  1  busy_count == 0 (registered).
- set_onehot  out  BITS  registered one-hot of the set accepted last cycle; all zero if none.
- set_err  out  1  one-cycle pulse: last cycle's set was rejected.
- clr_err  out  1  one-cycle pulse: last cycle's clear was rejected.

Behaviour:
- Reset (rst=1 at edge): busy=0, busy_count=0, empty=1, full=0, set_onehot=0, set_err=0, clr_err=0. Reset overrides all inputs. Reset mid-sequence discards all state.
- Latency: every output reflects requests from the previous cycle (1-cycle registered). There are no combinational input-to-output paths.
- Decode: internal combinational decode of set_idx and clr_idx to BITS-wide one-hot. An index >= BITS decodes to all-zero and counts as out of range.
- Priority: rst > flush > clear/set.
- Flush: busy=0, busy_count=0, set_onehot=0, set_err=0, clr_err=0. Any set/clr in the same cycle is ignored, with no error.
- Clear (clr_valid=1, no flush):
  - Effective if clr_idx is in range and busy[clr_idx]=1 in the pre-edge state.
  - Otherwise rejected: clr_err=1 next cycle, no state change from the clear.
- Set (set_valid=1, no flush):
  - Evaluated against the state after the same-cycle clear is applied.
  - Effective if set_idx is in range and that post-clear bit is 0.
  - Otherwise rejected: set_err=1 next cycle.
  - set_onehot = decoded one-hot if effective, else 0.
- Same index set and cleared in one cycle:
  - Entry busy: clear then set both effective; entry stays busy; count unchanged; no errors; set_onehot shows the entry.
  - Entry free: clear rejected (clr_err=1); set effective; entry becomes busy; count +1.
- Different indices in one cycle: each is evaluated independently; both may be effective.
- Count arithmetic: busy_count_next = busy_count + set_eff - clr_eff, range 0..BITS. No wrap is possible by construction. full/empty are computed from busy_count_next and registered.
- Invariant (checked by bench): busy_count == popcount(busy) every cycle.
- Set when full: rejected via the normal busy-bit check (set_err); count stays BITS. Clear when empty: clr_err.

Test Plan:
- Reset, then BITS=8, set_idx=3 -> next cycle busy=0x08, set_onehot=0x08, busy_count=1, empty=0.
- Sets 0..7 on consecutive cycles -> busy=0xFF, busy_count=8, full=1. Then set_idx=2 -> set_err=1, busy unchanged, set_onehot=0.
- busy=0x08; set_idx=3 and clr_idx=3 same cycle -> busy=0x08, count=1, no errors. Repeat with busy=0x00 -> busy=0x08, clr_err=1, count=1.
- BITS=6: set_idx=7 -> set_err=1, busy unchanged. clr_idx=5 while free -> clr_err=1.
- busy=0xA5 (count 4); flush together with set_idx=1 -> busy=0, count=0, empty=1, set_onehot=0, no error.
- Random set/clr/flush for 10k cycles against a reference model; assert busy_count==popcount(busy), full/empty consistent, and rst mid-stream yields the all-zero outputs next cycle.
